// File: rtl/qa_drv_hc_write_ack_tracker.sv
// Per-client outstanding-write tracker for the host-channel write path; routes RX write acks
// back to their clients. Optional watchdog enabled by QA_HC_WRACK_TIMEOUT_EN.
module qa_drv_hc_write_ack_tracker #(
  parameter int unsigned MDATA_W   = 13,
  parameter int unsigned CNT_W     = 8,
  parameter int unsigned TIMEOUT_W = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 issue_valid,
  input  logic [1:0]           issue_client,
  input  logic                 rx0_wrack_valid,
  input  logic [MDATA_W-1:0]   rx0_wrack_mdata,
  input  logic                 rx1_wrack_valid,
  input  logic [MDATA_W-1:0]   rx1_wrack_mdata,
`ifdef QA_HC_WRACK_TIMEOUT_EN
  input  logic [TIMEOUT_W-1:0] timeout_limit,
  output logic                 err_timeout,
`endif
  output logic [2:0]           ack_pulse,
  output logic [5:0]           ack_count,
  output logic [3*CNT_W-1:0]   outstanding,
  output logic [2:0]           client_full,
  output logic                 all_drained,
  output logic                 err_underflow,
  output logic                 err_overflow,
  output logic                 err_bad_client
);

  localparam logic [CNT_W-1:0] CntMax = '1;
  localparam int unsigned SumW = CNT_W + 2;

  logic                  rx0_v_q, rx0_v_d, rx1_v_q, rx1_v_d;
  logic [1:0]            rx0_id_q, rx0_id_d, rx1_id_q, rx1_id_d;
  logic [2:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]            ack_pulse_q, ack_pulse_d;
  logic [5:0]            ack_count_q, ack_count_d;
  logic                  all_drained_q, all_drained_d;
  logic                  err_under_q, err_under_d;
  logic                  err_over_q, err_over_d;
  logic                  err_bad_q, err_bad_d;

  logic                  inc;
  logic [1:0]            dec;
  logic [SumW-1:0]       sum, res;

  // Only the client id in mdata[1:0] is meaningful on the return path.
  logic unused_mdata;
  assign unused_mdata = ^{rx0_wrack_mdata[MDATA_W-1:2], rx1_wrack_mdata[MDATA_W-1:2]};

  always_comb begin
    rx0_v_d     = rx0_wrack_valid;
    rx0_id_d    = rx0_wrack_mdata[1:0];
    rx1_v_d     = rx1_wrack_valid;
    rx1_id_d    = rx1_wrack_mdata[1:0];
    cnt_d       = cnt_q;
    ack_pulse_d = '0;
    ack_count_d = '0;
    err_under_d = err_under_q;
    err_over_d  = err_over_q;
    inc         = 1'b0;
    dec         = '0;
    sum         = '0;
    res         = '0;

    for (int i = 0; i < 3; i++) begin
      inc = issue_valid && (issue_client == 2'(i));
      dec = {1'b0, rx0_v_q && (rx0_id_q == 2'(i))} + {1'b0, rx1_v_q && (rx1_id_q == 2'(i))};
      sum = SumW'(cnt_q[i]) + SumW'(inc);
      if (SumW'(dec) > sum) begin
        cnt_d[i]    = '0;
        err_under_d = 1'b1;
      end else begin
        res = sum - SumW'(dec);
        if (res > SumW'(CntMax)) begin
          cnt_d[i]   = CntMax;
          err_over_d = 1'b1;
        end else begin
          cnt_d[i] = res[CNT_W-1:0];
        end
      end
      ack_pulse_d[i]       = |dec;
      ack_count_d[2*i +: 2] = dec;
    end

    err_bad_d = err_bad_q
              | (issue_valid && (issue_client == 2'd3))
              | (rx0_v_q && (rx0_id_q == 2'd3))
              | (rx1_v_q && (rx1_id_q == 2'd3));

    // rx*_wrack_valid here is what the input stage will hold next cycle.
    all_drained_d = (cnt_d == '0) && !issue_valid && !rx0_wrack_valid && !rx1_wrack_valid;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rx0_v_q       <= 1'b0;
      rx0_id_q      <= '0;
      rx1_v_q       <= 1'b0;
      rx1_id_q      <= '0;
      cnt_q         <= '0;
      ack_pulse_q   <= '0;
      ack_count_q   <= '0;
      all_drained_q <= 1'b1;
      err_under_q   <= 1'b0;
      err_over_q    <= 1'b0;
      err_bad_q     <= 1'b0;
    end else begin
      rx0_v_q       <= rx0_v_d;
      rx0_id_q      <= rx0_id_d;
      rx1_v_q       <= rx1_v_d;
      rx1_id_q      <= rx1_id_d;
      cnt_q         <= cnt_d;
      ack_pulse_q   <= ack_pulse_d;
      ack_count_q   <= ack_count_d;
      all_drained_q <= all_drained_d;
      err_under_q   <= err_under_d;
      err_over_q    <= err_over_d;
      err_bad_q     <= err_bad_d;
    end
  end

`ifdef QA_HC_WRACK_TIMEOUT_EN
  logic [TIMEOUT_W-1:0] wd_q, wd_d;
  logic                 err_timeout_q, err_timeout_d;

  always_comb begin
    wd_d = wd_q;
    if ((cnt_q == '0) || rx0_v_q || rx1_v_q) begin
      wd_d = '0;
    end else if (wd_q != '1) begin
      wd_d = wd_q + 1'b1;
    end
    err_timeout_d = err_timeout_q | ((timeout_limit != '0) && (wd_q >= timeout_limit));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wd_q          <= '0;
      err_timeout_q <= 1'b0;
    end else begin
      wd_q          <= wd_d;
      err_timeout_q <= err_timeout_d;
    end
  end

  assign err_timeout = err_timeout_q;
`endif

  always_comb begin
    ack_pulse      = ack_pulse_q;
    ack_count      = ack_count_q;
    outstanding    = cnt_q;
    all_drained    = all_drained_q;
    err_underflow  = err_under_q;
    err_overflow   = err_over_q;
    err_bad_client = err_bad_q;
    for (int i = 0; i < 3; i++) begin
      client_full[i] = (cnt_q[i] == CntMax);
    end
  end

endmodule
